// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with registered, skew-free sync/blank/strobes
// Ports: pixel_clk clock, rst sync active-high reset, en pixel advance enable;
// hcounter/vcounter raster position; HS/VS sync of configurable polarity; blank outside active area;
// line_start/frame_start/vblank_start single-clock strobes on entering (0,*), (0,0), (0,V_ACTIVE).
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int CW = 11
) (
  input  logic          pixel_clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] hcounter,
  output logic [CW-1:0] vcounter,
  output logic          HS,
  output logic          VS,
  output logic          blank,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_ON = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_OFF = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_ON = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_OFF = CW'(V_ACTIVE + V_FP + V_SYNC);
  logic h_wrap;
  logic [CW-1:0] h_nxt, v_nxt;
  // Outputs are decoded from the position the counters move to, so they register alongside them.
  always_comb begin
    h_wrap = hcounter == H_LAST;
    h_nxt = h_wrap ? '0 : hcounter + CW'(1);
    v_nxt = !h_wrap ? vcounter : (vcounter == V_LAST) ? '0 : vcounter + CW'(1);
  end
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      hcounter <= H_LAST;
      vcounter <= V_LAST;
      HS <= ~HS_POL;
      VS <= ~VS_POL;
      blank <= 1'b1;
      line_start <= 1'b0;
      frame_start <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      line_start <= en && h_nxt == '0;
      frame_start <= en && h_nxt == '0 && v_nxt == '0;
      vblank_start <= en && h_nxt == '0 && v_nxt == V_ACT;
      if (en) begin
        hcounter <= h_nxt;
        vcounter <= v_nxt;
        HS <= (h_nxt >= HS_ON && h_nxt < HS_OFF) ? HS_POL : ~HS_POL;
        VS <= (v_nxt >= VS_ON && v_nxt < VS_OFF) ? VS_POL : ~VS_POL;
        blank <= !(h_nxt < H_ACT && v_nxt < V_ACT);
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for the default 800x525 raster and a tiny 8x6 raster
module tb_vga_timing_gen;
  logic pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;
  logic rst_a, en_a, rst_b, en_b;
  logic [10:0] hc_a, vc_a;
  logic [2:0] hc_b, vc_b;
  logic hs_a, vs_a, bl_a, ls_a, fs_a, vb_a;
  logic hs_b, vs_b, bl_b, ls_b, fs_b, vb_b;
  int checks = 0;
  int errors = 0;
  logic [27:0] q_a[$], q_b[$];
  int ah, av, bh, bv;
  int ls_cnt, fs_cnt, fs_last, fs_gap, cyc;
  vga_timing_gen dut_a (
    .pixel_clk(pixel_clk), .rst(rst_a), .en(en_a),
    .hcounter(hc_a), .vcounter(vc_a), .HS(hs_a), .VS(vs_a), .blank(bl_a),
    .line_start(ls_a), .frame_start(fs_a), .vblank_start(vb_a)
  );
  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(3)
  ) dut_b (
    .pixel_clk(pixel_clk), .rst(rst_b), .en(en_b),
    .hcounter(hc_b), .vcounter(vc_b), .HS(hs_b), .VS(vs_b), .blank(bl_b),
    .line_start(ls_b), .frame_start(fs_b), .vblank_start(vb_b)
  );
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s actual %0d required %0d", tag, got, exp);
    end
  endtask
  task automatic step_a(input logic e, input logic r);
    logic ls, fs, vb;
    logic [27:0] got, exp;
    @(negedge pixel_clk);
    en_a = e;
    rst_a = r;
    ls = 0; fs = 0; vb = 0;
    if (r) begin
      ah = 799; av = 524;
    end else if (e) begin
      ah = (ah == 799) ? 0 : ah + 1;
      if (ah == 0) av = (av == 524) ? 0 : av + 1;
      ls = ah == 0; fs = ls && av == 0; vb = ls && av == 480;
    end
    q_a.push_back({11'(ah), 11'(av), !(ah >= 656 && ah < 752), !(av >= 490 && av < 492),
                   !(ah < 640 && av < 480), ls, fs, vb});
    @(posedge pixel_clk);
    #1;
    got = {hc_a, vc_a, hs_a, vs_a, bl_a, ls_a, fs_a, vb_a};
    exp = q_a.pop_front();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL dut_a h/v/hs/vs/blank/ls/fs/vb actual %h required %h", got, exp);
    end
  endtask
  task automatic step_b(input logic e, input logic r);
    logic ls, fs, vb;
    logic [27:0] got, exp;
    @(negedge pixel_clk);
    en_b = e;
    rst_b = r;
    ls = 0; fs = 0; vb = 0;
    if (r) begin
      bh = 7; bv = 5;
    end else if (e) begin
      bh = (bh == 7) ? 0 : bh + 1;
      if (bh == 0) bv = (bv == 5) ? 0 : bv + 1;
      ls = bh == 0; fs = ls && bv == 0; vb = ls && bv == 3;
    end
    q_b.push_back({11'(bh), 11'(bv), bh >= 5 && bh < 7, bv == 4, !(bh < 4 && bv < 3), ls, fs, vb});
    @(posedge pixel_clk);
    #1;
    got = {8'd0, hc_b, 8'd0, vc_b, hs_b, vs_b, bl_b, ls_b, fs_b, vb_b};
    exp = q_b.pop_front();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL dut_b h/v/hs/vs/blank/ls/fs/vb actual %h required %h", got, exp);
    end
  endtask
  initial begin
    rst_a = 1'b1; en_a = 1'b0; rst_b = 1'b1; en_b = 1'b0;
    step_a(1'b1, 1'b1);
    check("reset_a_h", int'(hc_a), 799);
    check("reset_a_v", int'(vc_a), 524);
    step_a(1'b0, 1'b0);
    ls_cnt = 0;
    for (int i = 0; i < 1700; i++) begin
      step_a(1'b1, 1'b0);
      ls_cnt += int'(ls_a);
      if (i == 0) check("first_frame_start_a", int'(fs_a), 1);
    end
    check("line_start_count_a", ls_cnt, 3);
    for (int i = 0; i < 40; i++) step_a(i[0] == 1'b0, 1'b0);
    while (ah != 300) step_a(1'b1, 1'b0);
    step_a(1'b1, 1'b1);
    check("midrst_a_hs", int'(hs_a), 1);
    step_a(1'b1, 1'b0);
    check("after_rst_a_fs", int'(fs_a), 1);
    for (int i = 0; i < 5; i++) step_a(1'b1, 1'b0);
    step_a(1'b0, 1'b1);
    step_a(1'b0, 1'b0);
    step_b(1'b1, 1'b1);
    check("reset_b_h", int'(hc_b), 7);
    fs_cnt = 0; ls_cnt = 0; fs_last = -1; fs_gap = 0;
    for (cyc = 1; cyc <= 100; cyc++) begin
      step_b(1'b1, 1'b0);
      ls_cnt += int'(ls_b);
      if (fs_b) begin
        fs_cnt++;
        if (fs_last >= 0) fs_gap = cyc - fs_last;
        fs_last = cyc;
      end
    end
    check("frame_start_count_b", fs_cnt, 3);
    check("frame_period_b", fs_gap, 48);
    check("line_start_count_b", ls_cnt, 13);
    for (int i = 0; i < 60; i++) step_b(i[0] == 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) step_b(i % 3 != 2, 1'b0);
    step_b(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step_b(1'b1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
